// File: rtl/tmr0_timer_if.sv
// Register-file and pin-side signals of the Timer0 core.
// The master drives strobes, pin and bus data; the slave (timer) returns TMR0 and the overflow pulse.
interface tmr0_timer_if;
    logic       instr_tick;
    logic       t0cki;
    logic [7:0] option_reg_val;
    logic       option_reg_wr_en;
    logic       tmr0_reg_wr_en;
    logic [7:0] data_in;
    logic [7:0] tmr0_reg_val;
    logic       t0if_set;

    modport master (
        output instr_tick, t0cki, option_reg_val, option_reg_wr_en, tmr0_reg_wr_en, data_in,
        input  tmr0_reg_val, t0if_set
    );

    modport slave (
        input  instr_tick, t0cki, option_reg_val, option_reg_wr_en, tmr0_reg_wr_en, data_in,
        output tmr0_reg_val, t0if_set
    );
endinterface

// File: rtl/tmr0_timer.sv
// Timer0 core: TMR0 register, 8-bit prescaler, T0CKI edge detection and post-write count inhibit.
// Raises a one-clk t0if_set pulse when TMR0 wraps from 8'hFF to 8'h00 through an increment.
module tmr0_timer #(
    parameter logic [7:0] TMR0_RESET        = 8'h00,
    parameter int          WR_INHIBIT_CYCLES = 2
) (
    input logic          clk,
    input logic          rst,
    tmr0_timer_if.slave  bus
);

    localparam logic [1:0] INH_LOAD = 2'(WR_INHIBIT_CYCLES);

    // PS selects 1:2 .. 1:256; the mask is all-ones over the low PS+1 bits.
    function automatic logic [7:0] psc_mask(input logic [2:0] ps);
        logic [8:0] m;
        m = (9'd2 << ps) - 9'd1;
        return m[7:0];
    endfunction

    logic       t0cki_p0, t0cki_p1, t0cki_p2;
    logic [7:0] psc, psc_nxt;
    logic [1:0] inh, inh_nxt;
    logic [7:0] tmr0, tmr0_nxt;
    logic       t0if_nxt;
    logic       t0cs, t0se, psa;
    logic [7:0] mask;
    logic       src_evt, evt_ok, psc_hit, tmr0_inc;

    always_comb begin
        t0cs = bus.option_reg_val[5];
        t0se = bus.option_reg_val[4];
        psa  = bus.option_reg_val[3];
        mask = psc_mask(bus.option_reg_val[2:0]);

        if (!t0cs)
            src_evt = bus.instr_tick;
        else if (t0se)
            src_evt = ~t0cki_p1 & t0cki_p2;
        else
            src_evt = t0cki_p1 & ~t0cki_p2;

        evt_ok  = src_evt && (inh == 2'd0);
        psc_hit = ((psc & mask) == mask);
        // An OPTION write swallows the event for the prescaler path only.
        tmr0_inc = evt_ok && (psa || (!bus.option_reg_wr_en && psc_hit));

        psc_nxt = psc;
        if (bus.tmr0_reg_wr_en || bus.option_reg_wr_en || psa)
            psc_nxt = 8'd0;
        else if (evt_ok)
            psc_nxt = psc + 8'd1;

        inh_nxt = inh;
        if (bus.tmr0_reg_wr_en)
            inh_nxt = INH_LOAD;
        else if (bus.instr_tick && (inh != 2'd0))
            inh_nxt = inh - 2'd1;

        tmr0_nxt = tmr0;
        t0if_nxt = 1'b0;
        if (bus.tmr0_reg_wr_en) begin
            tmr0_nxt = bus.data_in;
        end else if (tmr0_inc) begin
            tmr0_nxt = tmr0 + 8'd1;
            t0if_nxt = (tmr0 == 8'hFF);
        end
    end

    // Stage p0..p2: two-flop synchronizer followed by the edge-history flop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            t0cki_p0 <= 1'b0;
            t0cki_p1 <= 1'b0;
            t0cki_p2 <= 1'b0;
        end else begin
            t0cki_p0 <= bus.t0cki;
            t0cki_p1 <= t0cki_p0;
            t0cki_p2 <= t0cki_p1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            psc  <= 8'd0;
            inh  <= 2'd0;
            tmr0 <= TMR0_RESET;
            bus.t0if_set <= 1'b0;
        end else begin
            psc  <= psc_nxt;
            inh  <= inh_nxt;
            tmr0 <= tmr0_nxt;
            bus.t0if_set <= t0if_nxt;
        end
    end

    assign bus.tmr0_reg_val = tmr0;

endmodule
